binary_bbox_detect: RTL and testbench

Frame-level bounding-box detector placed directly downstream of the YCbCr threshold/binarization stage in the Sobel_edge video path. It consumes the 16-bit binary pixel stream with its hsync/vsync/de timing, tracks the column/row extents and count of foreground pixels across each frame, and publishes the result once per frame on a stable register set with a one-cycle done pulse. Game/control logic reads these registers to locate the tracked object.

---
 rtl/binary_bbox_detect.sv | 197 +++++++++++++++++++
 tb/tb_binary_bbox_detect.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_bbox_detect.sv
// binary_bbox_detect
//   Tracks the bounding box and count of foreground pixels (i_binary == 16'h0000)
//   in a binarized video stream. Results are published once per frame, two cycles
//   after the vsync rising edge that ends the frame, together with a one-cycle
//   o_frame_done pulse. Outputs hold their values between commits.
//
// Ports
//   pixelclk          pixel clock, all state on its rising edge
//   reset             synchronous active-high reset
//   i_binary          binary pixel, 16'h0000 = foreground
//   i_hsync           line sync, not used for counting
//   i_vsync           frame sync, rising edge marks frame start
//   i_de              active pixel qualifier
//   o_x_min/o_x_max   committed horizontal extent
//   o_y_min/o_y_max   committed vertical extent
//   o_pix_cnt         committed foreground count (saturating)
//   o_valid           committed count reached MIN_PIXELS
//   o_frame_done      one-cycle pulse when the outputs update
module binary_bbox_detect #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned CW         = 11
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic [15:0]   i_binary,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  output logic [CW-1:0] o_x_min,
  output logic [CW-1:0] o_x_max,
  output logic [CW-1:0] o_y_min,
  output logic [CW-1:0] o_y_max,
  output logic [19:0]   o_pix_cnt,
  output logic          o_valid,
  output logic          o_frame_done
);

  localparam logic [CW-1:0] ImgWC  = CW'(IMG_W);
  localparam logic [CW-1:0] ImgHC  = CW'(IMG_H);
  localparam logic [19:0]   MinPix = 20'(MIN_PIXELS);
  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [19:0]   AccMax = '1;

  typedef enum logic [1:0] {StWaitSof, StActive, StCommit} state_e;

  state_e state_q, state_d;

  logic vs_d, de_d;
  logic vs_rise, de_fall;

  logic [CW-1:0] x_cnt_q, x_cnt_d;
  logic [CW-1:0] y_cnt_q, y_cnt_d;

  logic [CW-1:0] acc_x_min_q, acc_x_min_d;
  logic [CW-1:0] acc_x_max_q, acc_x_max_d;
  logic [CW-1:0] acc_y_min_q, acc_y_min_d;
  logic [CW-1:0] acc_y_max_q, acc_y_max_d;
  logic [19:0]   acc_cnt_q, acc_cnt_d;

  logic commit, clear_acc, pix_ok;

  // hsync is carried for port compatibility only
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  assign vs_rise = i_vsync & ~vs_d;
  assign de_fall = de_d & ~i_de;

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    clear_acc = 1'b0;
    unique case (state_q)
      StWaitSof: begin
        // Partial frame seen after reset is discarded, no commit
        if (vs_rise) begin
          state_d   = StActive;
          clear_acc = 1'b1;
        end
      end
      StActive: begin
        if (vs_rise) state_d = StCommit;
      end
      StCommit: begin
        // A vsync rise here cannot happen in legal timing and is ignored
        state_d   = StActive;
        commit    = 1'b1;
        clear_acc = 1'b1;
      end
      default: state_d = StWaitSof;
    endcase
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    if (vs_rise || de_fall) begin
      x_cnt_d = '0;
    end else if (i_de && (x_cnt_q != CntMax)) begin
      x_cnt_d = x_cnt_q + 1'b1;
    end
  end

  always_comb begin
    y_cnt_d = y_cnt_q;
    if (vs_rise) begin
      y_cnt_d = '0;
    end else if (de_fall && (y_cnt_q != CntMax)) begin
      y_cnt_d = y_cnt_q + 1'b1;
    end
  end

  // Pixels arriving in the commit cycle belong to the new frame
  assign pix_ok = i_de && (i_binary == 16'h0000) && (x_cnt_q < ImgWC) && (y_cnt_q < ImgHC) &&
                  ((state_q == StActive) || (state_q == StCommit)) && !vs_rise;

  always_comb begin
    if (clear_acc) begin
      acc_x_min_d = '1;
      acc_x_max_d = '0;
      acc_y_min_d = '1;
      acc_y_max_d = '0;
      acc_cnt_d   = '0;
    end else begin
      acc_x_min_d = acc_x_min_q;
      acc_x_max_d = acc_x_max_q;
      acc_y_min_d = acc_y_min_q;
      acc_y_max_d = acc_y_max_q;
      acc_cnt_d   = acc_cnt_q;
    end
    if (pix_ok) begin
      if (x_cnt_q < acc_x_min_d) acc_x_min_d = x_cnt_q;
      if (x_cnt_q > acc_x_max_d) acc_x_max_d = x_cnt_q;
      if (y_cnt_q < acc_y_min_d) acc_y_min_d = y_cnt_q;
      if (y_cnt_q > acc_y_max_d) acc_y_max_d = y_cnt_q;
      if (acc_cnt_d != AccMax) acc_cnt_d = acc_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_q     <= StWaitSof;
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      vs_d        <= i_vsync;
      de_d        <= i_de;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_pix_cnt    <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= commit;
      if (commit) begin
        o_pix_cnt <= acc_cnt_q;
        if (acc_cnt_q >= MinPix) begin
          o_x_min <= acc_x_min_q;
          o_x_max <= acc_x_max_q;
          o_y_min <= acc_y_min_q;
          o_y_max <= acc_y_max_q;
          o_valid <= 1'b1;
        end else begin
          o_x_min <= '0;
          o_x_max <= '0;
          o_y_min <= '0;
          o_y_max <= '0;
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Directed bench for binary_bbox_detect on an 8x6 image. Two instances share the
// stimulus: dut1 with MIN_PIXELS=1 and dut4 with MIN_PIXELS=4.
module tb_binary_bbox_detect;

  localparam int unsigned CW = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bin;
  logic        hs, vs, de;

  logic [CW-1:0] x_min1, x_max1, y_min1, y_max1;
  logic [CW-1:0] x_min4, x_max4, y_min4, y_max4;
  logic [19:0]   cnt1, cnt4;
  logic          valid1, valid4, done1, done4;

  always #5 clk = ~clk;

  binary_bbox_detect #(.IMG_W(8), .IMG_H(6), .MIN_PIXELS(1), .CW(CW)) dut1 (
    .pixelclk(clk), .reset(reset), .i_binary(bin), .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .o_x_min(x_min1), .o_x_max(x_max1), .o_y_min(y_min1), .o_y_max(y_max1),
    .o_pix_cnt(cnt1), .o_valid(valid1), .o_frame_done(done1)
  );

  binary_bbox_detect #(.IMG_W(8), .IMG_H(6), .MIN_PIXELS(4), .CW(CW)) dut4 (
    .pixelclk(clk), .reset(reset), .i_binary(bin), .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .o_x_min(x_min4), .o_x_max(x_max4), .o_y_min(y_min4), .o_y_max(y_max4),
    .o_pix_cnt(cnt4), .o_valid(valid4), .o_frame_done(done4)
  );

  wire [65:0] out1 = {x_min1, x_max1, y_min1, y_max1, cnt1, valid1, done1};
  wire [65:0] out4 = {x_min4, x_max4, y_min4, y_max4, cnt4, valid4, done4};

  bit fg [0:7][0:15];
  int checks   = 0;
  int failures = 0;

  localparam logic [6:1] PulseAt2 = 6'b000010;

  // Expected output vector; done is always 0 at the sampling points used
  function automatic logic [65:0] pk(int xmin, int xmax, int ymin, int ymax, int cnt, bit v);
    return {11'(xmin), 11'(xmax), 11'(ymin), 11'(ymax), 20'(cnt), v, 1'b0};
  endfunction

  task automatic clear_fg();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) fg[y][x] = 1'b0;
  endtask

  task automatic send_line(input int y, input int len);
    for (int x = 0; x < len; x++) begin
      @(negedge clk);
      de  = 1'b1;
      bin = fg[y][x] ? 16'h0000 : 16'hFFFF;
    end
    @(negedge clk);
    de  = 1'b0;
    bin = 16'hFFFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int len, input int lines);
    for (int y = 0; y < lines; y++) send_line(y, len);
  endtask

  // Raises vsync and records o_frame_done over the following six cycles
  task automatic vsync_pulse(input bit rise_pixel, output logic [6:1] s1, output logic [6:1] s4);
    s1 = '0;
    s4 = '0;
    @(negedge clk);
    vs = 1'b1;
    if (rise_pixel) begin
      de  = 1'b1;
      bin = 16'h0000;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      s1[k] = done1;
      s4[k] = done4;
      if (k == 1) begin
        de  = 1'b0;
        bin = 16'hFFFF;
      end
      if (k == 3) vs = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out1 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_dut1: got %h expected %h", out1, pk(0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [6:1] s1, s4;
    clear_fg();
    fg[2][3] = 1'b1;
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s1 !== 6'b0) begin
      failures++;
      $display("FAIL first_sof_no_done: got %b expected %b", s1, 6'b0);
    end
    checks++;
    if (out1 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL first_sof_outputs: got %h expected %h", out1, pk(0, 0, 0, 0, 0, 0));
    end
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s1 !== PulseAt2) begin
      failures++;
      $display("FAIL single_done_timing: got %b expected %b", s1, PulseAt2);
    end
    checks++;
    if (out1 !== pk(3, 3, 2, 2, 1, 1)) begin
      failures++;
      $display("FAIL single_pixel_dut1: got %h expected %h", out1, pk(3, 3, 2, 2, 1, 1));
    end
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 1, 0)) begin
      failures++;
      $display("FAIL single_pixel_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_min_pixels();
    logic [6:1] s1, s4;
    clear_fg();
    fg[1][1] = 1'b1;
    fg[1][6] = 1'b1;
    fg[5][2] = 1'b1;
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 3, 0)) begin
      failures++;
      $display("FAIL three_pixels_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 3, 0));
    end
    checks++;
    if (out1 !== pk(1, 6, 1, 5, 3, 1)) begin
      failures++;
      $display("FAIL three_pixels_dut1: got %h expected %h", out1, pk(1, 6, 1, 5, 3, 1));
    end
    fg[4][0] = 1'b1;
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s4 !== PulseAt2) begin
      failures++;
      $display("FAIL four_pixels_done: got %b expected %b", s4, PulseAt2);
    end
    checks++;
    if (out4 !== pk(0, 6, 1, 5, 4, 1)) begin
      failures++;
      $display("FAIL four_pixels_dut4: got %h expected %h", out4, pk(0, 6, 1, 5, 4, 1));
    end
    checks++;
    if (out1 !== pk(0, 6, 1, 5, 4, 1)) begin
      failures++;
      $display("FAIL four_pixels_dut1: got %h expected %h", out1, pk(0, 6, 1, 5, 4, 1));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [6:1] s1, s4;
    clear_fg();
    for (int x = 0; x < 5; x++) fg[0][x] = 1'b1;
    send_line(0, 8);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out1 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL mid_reset_dut1: got %h expected %h", out1, pk(0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL mid_reset_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b0;
    for (int y = 1; y < 6; y++) send_line(y, 8);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s1 !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done: got %b expected %b", s1, 6'b0);
    end
    clear_fg();
    fg[3][5] = 1'b1;
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s1 !== PulseAt2) begin
      failures++;
      $display("FAIL after_reset_done: got %b expected %b", s1, PulseAt2);
    end
    checks++;
    if (out1 !== pk(5, 5, 3, 3, 1, 1)) begin
      failures++;
      $display("FAIL after_reset_dut1: got %h expected %h", out1, pk(5, 5, 3, 3, 1, 1));
    end
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 1, 0)) begin
      failures++;
      $display("FAIL after_reset_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_out_of_range();
    logic [6:1] s1, s4;
    clear_fg();
    for (int y = 0; y < 6; y++) begin
      fg[y][8] = 1'b1;
      fg[y][9] = 1'b1;
    end
    for (int x = 0; x < 10; x++) fg[6][x] = 1'b1;
    send_frame(10, 7);
    // Foreground also presented in the vsync-rise cycle
    vsync_pulse(1'b1, s1, s4);
    checks++;
    if (s1 !== PulseAt2) begin
      failures++;
      $display("FAIL out_of_range_done: got %b expected %b", s1, PulseAt2);
    end
    checks++;
    if (out1 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL out_of_range_dut1: got %h expected %h", out1, pk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_background();
    logic [6:1] s1, s4;
    clear_fg();
    send_frame(8, 6);
    vsync_pulse(1'b0, s1, s4);
    checks++;
    if (s4 !== PulseAt2) begin
      failures++;
      $display("FAIL background_done: got %b expected %b", s4, PulseAt2);
    end
    checks++;
    if (out1 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL background_dut1: got %h expected %h", out1, pk(0, 0, 0, 0, 0, 0));
    end
    checks++;
    if (out4 !== pk(0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL background_dut4: got %h expected %h", out4, pk(0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    reset = 1'b1;
    bin   = 16'hFFFF;
    hs    = 1'b0;
    vs    = 1'b0;
    de    = 1'b0;
    test_reset();
    test_first_frame();
    test_min_pixels();
    test_reset_mid_frame();
    test_out_of_range();
    test_background();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
